cla_adder_pipe: RTL and testbench

CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

---
 rtl/cla_pkg.sv | 15 +
 rtl/cla_group4.sv | 18 +
 rtl/cla_adder_pipe.sv | 131 +++++++++++++
 tb/tb_cla_adder_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and parameter legality checks for the CLA pipeline
package cla_pkg;

  localparam int GRP_W = 4;

  function automatic bit width_ok(input int width);
    return (width >= GRP_W) && ((width % GRP_W) == 0);
  endfunction

  // Short-circuit keeps the modulo away from stages == 0.
  function automatic bit stages_ok(input int width, input int stages);
    return (stages >= 1) && (((width / GRP_W) % stages) == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - 4-bit carry-lookahead group: carries C[4:1] and group sum
module cla_group4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [4:1] c,
  output logic [3:0] s
);

  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c[3], c[2], c[1], ci};

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined carry-lookahead adder/subtractor with valid/ready flow control
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG  = WIDTH / GRP_W;
  localparam int GPS = NG / STAGES;
  localparam int SW  = GPS * GRP_W;

  if (!width_ok(WIDTH) || !stages_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("cla_adder_pipe: illegal WIDTH/STAGES combination");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_in0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c_in0    = sub | ci;

  // Stage k consumes the low SW bits of what is left of the operands and
  // appends its group sums above the sum bits produced by earlier stages.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;

    logic [WIDTH-LO-1:0] a_i;
    logic [WIDTH-LO-1:0] b_i;
    logic                c_i;
    logic                v_i;
    logic [SW-1:0]       grp_s;
    logic [LO+SW-1:0]    s_n;
    logic [GPS:0]        cc;

    if (k == 0) begin : g_head
      assign a_i = a;
      assign b_i = b_eff;
      assign c_i = c_in0;
      assign v_i = in_valid;
      assign s_n = grp_s;
    end else begin : g_body
      assign a_i = g_stage[k-1].g_reg.a_q;
      assign b_i = g_stage[k-1].g_reg.b_q;
      assign c_i = g_stage[k-1].g_reg.c_q;
      assign v_i = g_stage[k-1].g_reg.v_q;
      assign s_n = {grp_s, g_stage[k-1].g_reg.s_q};
    end

    assign cc[0] = c_i;

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      logic [3:0] p_w;
      logic [3:0] g_w;
      logic [4:1] c_w;

      assign p_w = a_i[j*GRP_W +: GRP_W] ^ b_i[j*GRP_W +: GRP_W];
      assign g_w = a_i[j*GRP_W +: GRP_W] & b_i[j*GRP_W +: GRP_W];

      cla_group4 u_grp (
        .p  (p_w),
        .g  (g_w),
        .ci (cc[j]),
        .c  (c_w),
        .s  (grp_s[j*GRP_W +: GRP_W])
      );

      assign cc[j+1] = c_w[4];
    end

    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-LO-SW-1:0] a_q;
      logic [WIDTH-LO-SW-1:0] b_q;
      logic [LO+SW-1:0]       s_q;
      logic                   c_q;
      logic                   v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          v_q <= v_i;
          c_q <= cc[GPS];
          s_q <= s_n;
          a_q <= a_i[WIDTH-LO-1:SW];
          b_q <= b_i[WIDTH-LO-1:SW];
        end
      end
    end
  end

  // The last stage's combinational result lands directly in the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= g_stage[STAGES-1].v_i;
      sum       <= g_stage[STAGES-1].s_n;
      cout      <= g_stage[STAGES-1].cc[GPS];
      ovf       <= g_stage[STAGES-1].g_grp[GPS-1].c_w[3] ^ g_stage[STAGES-1].cc[GPS];
      zero      <= (g_stage[STAGES-1].s_n == '0);
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - scoreboard bench for cla_adder_pipe (WIDTH=16, STAGES=2)
module tb_cla_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;

  logic [18:0] sb[$];

  cla_adder_pipe #(.WIDTH(16), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {cout, ovf, zero, sum}
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [15:0] yy;
    logic [16:0] full;
    logic        cin;
    logic        v;
    yy   = s ? ~y : y;
    cin  = s ? 1'b1 : c;
    full = {1'b0, x} + {1'b0, yy} + {16'b0, cin};
    v    = (x[15] == yy[15]) && (full[15] != x[15]);
    return {full[16], v, (full[15:0] == 16'h0), full[15:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {31'b0, out_valid}, 32'd0);
        end else begin
          check("sb_beat", {13'b0, cout, ovf, zero, sum}, {13'b0, sb.pop_front()});
          n_pop++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, ci, sub));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (sb.size() != 0 && n < 40) begin
      next_cycle();
      n++;
    end
    check({tag, "_drain"}, sb.size(), 32'd0);
  endtask

  task automatic single_beat(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic c, input logic s, input logic [18:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x; b = y; ci = c; sub = s;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_lat"}, {31'b0, out_valid}, 32'd1);
    check(tag, {13'b0, cout, ovf, zero, sum}, {13'b0, exp});
    next_cycle();
  endtask

  initial begin
    int base;
    int sent;
    int cyc;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a = 16'h1234; b = 16'h4321; ci = 1'b1; sub = 1'b0;
    next_cycle();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_flags", {13'b0, cout, ovf, zero, sum}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    next_cycle();

    single_beat("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
    single_beat("sovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});
    single_beat("sub",   16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
    single_beat("ci",    16'h0FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 16'h1000});
    single_beat("subci", 16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0, 16'h7FFF});
    drain("directed");

    // Stall: three back-to-back beats against a blocked output.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; ci = 1'b0; sub = 1'b0;
    next_cycle();
    a = 16'hF000; b = 16'h1000; ci = 1'b1;
    next_cycle();
    a = 16'h0100; b = 16'h0200; ci = 1'b0; sub = 1'b1;
    #1;
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("hold_out", {12'b0, out_valid, cout, ovf, zero, sum}, {12'b0, 1'b1, 3'b000, 16'h3333});
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      next_cycle();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    next_cycle();
    base = n_pop;
    drain("stall");
    check("stall_count", n_pop - base, 32'd2);

    // Reset with two beats in flight.
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; ci = 1'b0; sub = 1'b0;
    next_cycle();
    a = 16'h0001; b = 16'h0001;
    next_cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    sb.delete();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_no_ghost", {31'b0, out_valid}, 32'd0);
      next_cycle();
    end

    // Random traffic with random back-pressure.
    base = n_pop;
    sent = 0;
    cyc  = 0;
    in_valid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        case ($urandom_range(0, 4))
          0: a = 16'hFFFF;
          1: a = 16'h7FFF;
          2: a = 16'h8000;
          default: a = 16'($urandom);
        endcase
        b   = ($urandom_range(0, 5) == 0) ? 16'h0001 : 16'($urandom);
        ci  = 1'($urandom);
        sub = 1'($urandom);
      end
      #1;
      acc = in_valid && in_ready;
      next_cycle();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check("rand_sent", sent, 32'd1000);
    drain("rand");
    check("rand_count", n_pop - base, 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
